// File: rtl/ctrl_signal_types_pkg.sv
// Shared control-path types for the memory request fabric.
// The arbiter, its ingress queue and the producers all agree on these.
package ctrl_signal_types;

  localparam int REQ_QUEUE_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    MEM_OP_READ   = 2'd0,
    MEM_OP_WRITE  = 2'd1,
    MEM_OP_ATOMIC = 2'd2,
    MEM_OP_FLUSH  = 2'd3
  } mem_op_e;

  typedef struct packed {
    mem_op_e     op;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_request_t;

endpackage

// File: rtl/arbiter_ingress_queue_req_fifo.sv
// Single-port synchronous FIFO of mem_request_t with count-based full/empty.
// The head is forced to zero while empty so downstream never sees stale data.
module req_fifo
  import ctrl_signal_types::*;
#(
  parameter int DEPTH = REQ_QUEUE_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  mem_request_t                 push_data,
  input  logic                         pop,
  output mem_request_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("req_fifo: DEPTH must be a power of two and at least 2");
  end

  mem_request_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             push_fire;
  logic             pop_fire;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count gates visibility, so stale words are
  // never observed and the array can map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_q] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/arbiter_ingress_queue.sv
// Per-port request buffering in front of the round-robin arbiter: one FIFO per
// producer, heads exposed as req/head_request, popped on grant.
module arbiter_ingress_queue
  import ctrl_signal_types::*;
#(
  parameter int NUM_INPUT_PORT = 2,
  parameter int DEPTH          = REQ_QUEUE_DEPTH_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic         [NUM_INPUT_PORT-1:0]           in_valid,
  output logic         [NUM_INPUT_PORT-1:0]           in_ready,
  input  mem_request_t [NUM_INPUT_PORT-1:0]           in_request,
  output logic         [NUM_INPUT_PORT-1:0]           req,
  input  logic         [NUM_INPUT_PORT-1:0]           grant,
  output mem_request_t [NUM_INPUT_PORT-1:0]           head_request,
  output logic [NUM_INPUT_PORT-1:0][$clog2(DEPTH+1)-1:0] occupancy,
  output logic         [NUM_INPUT_PORT-1:0]           grant_err
);

  logic [NUM_INPUT_PORT-1:0] push;
  logic [NUM_INPUT_PORT-1:0] pop;
  logic [NUM_INPUT_PORT-1:0] full;
  logic [NUM_INPUT_PORT-1:0] grant_err_q, grant_err_d;

  for (genvar i = 0; i < NUM_INPUT_PORT; i++) begin : g_port
    // Ready depends only on stored count (and reset), never on grant, so a
    // full queue refuses a push even in a cycle where it is also popped.
    assign in_ready[i] = reset_n && !full[i];
    assign push[i]     = in_valid[i] && in_ready[i];
    assign req[i]      = (occupancy[i] != '0);
    assign pop[i]      = grant[i] && req[i];

    req_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push[i]),
      .push_data(in_request[i]),
      .pop      (pop[i]),
      .head     (head_request[i]),
      .count    (occupancy[i]),
      .full     (full[i])
    );
  end

  assign grant_err_d = grant_err_q | (grant & ~req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) grant_err_q <= '0;
    else          grant_err_q <= grant_err_d;
  end

  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arbiter_ingress_queue.sv
// Scoreboard bench for arbiter_ingress_queue: directed test-plan scenarios
// followed by randomized traffic, checked against per-port reference queues.
module tb_arbiter_ingress_queue;
  import ctrl_signal_types::*;

  localparam int NP    = 2;
  localparam int DEPTH = REQ_QUEUE_DEPTH_DEFAULT;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                         clk;
  logic                         reset_n;
  logic         [NP-1:0]        in_valid;
  logic         [NP-1:0]        in_ready;
  mem_request_t [NP-1:0]        in_request;
  logic         [NP-1:0]        req;
  logic         [NP-1:0]        grant;
  mem_request_t [NP-1:0]        head_request;
  logic [NP-1:0][CW-1:0]        occupancy;
  logic         [NP-1:0]        grant_err;

  arbiter_ingress_queue #(
    .NUM_INPUT_PORT(NP),
    .DEPTH         (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_request  (in_request),
    .req         (req),
    .grant       (grant),
    .head_request(head_request),
    .occupancy   (occupancy),
    .grant_err   (grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of accepted payloads per port, plus counts
  // that become visible one edge after the stimulus that caused them.
  mem_request_t sb_q [NP][$];
  int           exp_cnt [NP];
  int           nxt_cnt [NP];
  logic [NP-1:0] exp_err;
  logic [NP-1:0] nxt_err;
  bit            in_rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mem_request_t rand_req();
    mem_request_t r;
    r.op    = mem_op_e'($urandom_range(0, 3));
    r.id    = 4'($urandom);
    r.addr  = 16'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      sb_q[i].delete();
      exp_cnt[i] = 0;
      nxt_cnt[i] = 0;
    end
    exp_err = '0;
    nxt_err = '0;
  endtask

  // One clock of stimulus: commit the previous edge into the model, then
  // drive new inputs and record what the coming edge should accept.
  task automatic drive_cycle(input logic [NP-1:0] v, input logic [NP-1:0] g);
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) exp_cnt[i] = nxt_cnt[i];
    exp_err  = nxt_err;
    in_valid = v;
    grant    = g;
    for (int i = 0; i < NP; i++) begin
      in_request[i] = rand_req();
      if (g[i] && exp_cnt[i] == 0) nxt_err[i] = 1'b1;
      if (g[i] && exp_cnt[i] != 0) nxt_cnt[i]--;
      if (v[i] && exp_cnt[i] != DEPTH) begin
        sb_q[i].push_back(in_request[i]);
        nxt_cnt[i]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle('0, '0);
  endtask

  // Monitor: compares visible state every cycle and consumes the scoreboard
  // whenever a granted head leaves the queue.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        check($sformatf("req[%0d]", i), 64'(req[i]), 64'(!in_rst && exp_cnt[i] != 0));
        check($sformatf("occupancy[%0d]", i), 64'(occupancy[i]), 64'(exp_cnt[i]));
        check($sformatf("in_ready[%0d]", i), 64'(in_ready[i]),
              64'(!in_rst && exp_cnt[i] != DEPTH));
        check($sformatf("grant_err[%0d]", i), 64'(grant_err[i]), 64'(exp_err[i]));
        if (exp_cnt[i] == 0) begin
          check($sformatf("head_empty[%0d]", i), 64'(head_request[i]), 64'(0));
        end else if (!in_rst && grant[i]) begin
          check($sformatf("pop_data[%0d]", i), 64'(head_request[i]), 64'(sb_q[i].pop_front()));
        end else begin
          check($sformatf("head[%0d]", i), 64'(head_request[i]), 64'(sb_q[i][0]));
        end
      end
    end
  end

  // Asserts reset between edges while traffic is queued, checks the
  // asynchronous clear, then releases with inputs quiet.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    in_rst  = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_req", 64'(req), 64'(0));
    check("async_occ", 64'(occupancy), 64'(0));
    check("async_err", 64'(grant_err), 64'(0));
    check("async_ready", 64'(in_ready), 64'(0));
    clear_model();
    in_valid = '1;
    grant    = '1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = '0;
    grant    = '0;
    #1;
    reset_n = 1'b1;
    in_rst  = 1'b0;
    #1;
    check("release_ready", 64'(in_ready), 64'({NP{1'b1}}));
  endtask

  initial begin
    in_rst     = 1'b1;
    reset_n    = 1'b0;
    in_valid   = '0;
    grant      = '0;
    in_request = '0;
    clear_model();
    #2;
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_head", 64'(head_request), 64'(0));
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    in_rst  = 1'b0;
    #1;
    check("first_ready", 64'(in_ready), 64'({NP{1'b1}}));

    // Single push on port 0, visible one cycle later.
    drive_cycle(2'b01, 2'b00);
    idle(1);

    // Fill port 1, hold a fifth push, then pop-while-full and refill.
    repeat (4) drive_cycle(2'b10, 2'b00);
    drive_cycle(2'b10, 2'b00);
    drive_cycle(2'b10, 2'b10);
    drive_cycle(2'b10, 2'b00);
    idle(1);

    // Port 0 at count 2 with simultaneous push and grant, wrapping pointers.
    drive_cycle(2'b01, 2'b00);
    repeat (6) drive_cycle(2'b01, 2'b01);
    repeat (2) drive_cycle(2'b00, 2'b01);
    idle(1);

    // Grant on an empty port with a push in the same cycle.
    drive_cycle(2'b01, 2'b01);
    idle(2);

    // Drain port 1, then queue three entries per port and reset mid-burst.
    repeat (4) drive_cycle(2'b00, 2'b10);
    drive_cycle(2'b00, 2'b01);
    repeat (3) drive_cycle(2'b11, 2'b00);
    mid_reset();
    idle(2);

    // Randomized traffic with an extra reset partway through.
    for (int c = 0; c < 400; c++) begin
      logic [NP-1:0] v;
      logic [NP-1:0] g;
      int            r;
      v = NP'($urandom);
      r = $urandom_range(0, 19);
      if (r < 8)       g = 2'b00;
      else if (r < 13) g = 2'b01;
      else if (r < 18) g = 2'b10;
      else             g = 2'b11;
      drive_cycle(v, g);
      if (c == 200) mid_reset();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter_ingress_queue.md
Name: arbiter_ingress_queue

Overview:
Per-port request buffering stage that sits directly upstream of the round-robin request arbiter.
- Accepts mem_request_t from NUM_INPUT_PORT producers over valid/ready handshakes.
- Holds each port's requests in its own FIFO.
- Presents each FIFO head to the arbiter as req[i]/head_request[i].
- Pops a head in the cycle the arbiter asserts grant[i].
- Decouples bursty producers from arbitration so a stalled output port never drops requests.

Parameters:
NUM_INPUT_PORT, 2, number of producer ports; must match the downstream arbiter.
DEPTH, 4, entries per port FIFO; power of two, at least 2, enforced by an elaboration-time assertion.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  [NUM_INPUT_PORT]  producer i presents a request.
in_ready  output  [NUM_INPUT_PORT]  port i FIFO can accept this cycle.
in_request  input  mem_request_t [NUM_INPUT_PORT]  producer payloads.
req  output  [NUM_INPUT_PORT]  port i FIFO non-empty; drives the arbiter req.
grant  input  [NUM_INPUT_PORT]  arbiter grant; one-hot or zero.
head_request  output  mem_request_t [NUM_INPUT_PORT]  FIFO head per port; drives the arbiter in_request.
occupancy  output  [NUM_INPUT_PORT][$clog2(DEPTH+1)]  entries held per port.
grant_err  output  [NUM_INPUT_PORT]  sticky: grant[i] seen while req[i]=0.

Behaviour:
Reset:
- Asynchronous assertion of reset_n clears all rd/wr pointers, counts and grant_err.
- While reset is asserted: req=0, in_ready=0, occupancy=0, head_request='0.
- First cycle after deassertion: in_ready=all ones.
- Storage arrays are not reset.
- Reset mid-operation discards all queued entries; a push or pop in the reset cycle has no effect.

Push (per port i):
- Fires when in_valid[i] && in_ready[i].
- Writes mem[wr_ptr] and advances wr_ptr modulo DEPTH.
- in_ready[i] = (count[i] != DEPTH). It is registered-state only, with no combinational path from grant, so a full FIFO refuses a push even when a pop happens in the same cycle.

Pop (per port i):
- Fires when grant[i] && req[i]; advances rd_ptr modulo DEPTH.
- head_request[i] is stable throughout the grant cycle, because the arbiter samples it at that edge.

Visibility:
- No bypass path. A request pushed at edge N appears on req/head_request after edge N (one-cycle latency).
- An empty FIFO with a simultaneous push and grant ignores the grant and sets grant_err[i].

Count:
- count[i] next = count + push - pop. Simultaneous push and pop leave it unchanged while both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count, never from pointer compare.
- occupancy[i] = count[i].

Outputs when empty:
- req[i] = (count[i] != 0).
- head_request[i] = '0 when empty, mem[rd_ptr] otherwise.

grant_err:
- Sets on grant[i] && !req[i].
- Cleared only by reset.
- Sticky-bit updates never block the datapath.

Multiple grant bits are illegal upstream behaviour. Each port acts independently on its own bit.

Decomposition:
- mem_request_t comes from the existing ctrl_signal_types package.
- Add a new package constant REQ_QUEUE_DEPTH_DEFAULT = 4 there for shared sizing.
- Sub-module req_fifo: single-port DEPTH-entry synchronous FIFO with push/pop/count/head. Instantiated NUM_INPUT_PORT times via generate.
- Top level adds the handshake mapping and grant_err.

Test Plan:
- Reset then push 1 request on port 0 at cycle 1 -> req=2'b01 from cycle 2, head_request[0] matches, occupancy[0]=1.
- Push 4 requests on port 1 (DEPTH=4) with grant=0 -> in_ready[1]=0 after the 4th push; a 5th push with in_valid held is not accepted; occupancy[1]=4.
- Port 1 full, grant[1]=1 for 1 cycle with in_valid[1]=1 -> pop A, push refused that cycle, occupancy 3; next cycle push accepted, occupancy 4, order preserved.
- Port 0 at count 2, simultaneous push and grant for 6 cycles -> occupancy stays 2, pointers wrap, data drained in FIFO order with no loss or duplication.
- grant[0]=1 while port 0 empty and in_valid[0]=1 -> grant_err[0]=1 next cycle and stays set, entry still enqueued, occupancy[0]=1.
- Assert reset_n low mid-burst with 3 entries queued on each port -> req, occupancy, grant_err cleared immediately (asynchronously); in_ready=0 during reset and all ones after release.
